// File: rtl/spi_mirror_fifo_pkg.sv
// Shared types and constants for spi_mirror_fifo: replay states, reset values
// and the saturating error-counter helper used when SPI_MIRROR_FIFO_ERR_CNT_EN is set.
package spi_mirror_fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_TRAIL = 3'd3,
      ST_GAP   = 3'd4
   } replay_state_e;

   localparam logic RST_SCLK = 1'b0;
   localparam logic RST_CS_N = 1'b1;
   localparam logic RST_FLAG = 1'b0;

   localparam int              CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // A clear and a new event in the same cycle leave the count at one.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic evt, input logic clr);
      if (clr) return evt ? CNT_W'(1) : '0;
      if (evt && cnt != CNT_MAX) return cnt + 1'b1;
      return cnt;
   endfunction

endpackage

// File: rtl/spi_mirror_fifo_mem.sv
// Single-clock FIFO with registered level/full/empty; a pop frees room for a
// push in the same cycle, so push+pop while full keeps the level unchanged.
module spi_mirror_fifo_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] LVL_ONE     = LW'(1);
   localparam logic [LW-1:0] LVL_FULL_M1 = LW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   // push/pop are single-cycle requests: a pop is taken when not empty, a push
   // when not full or when a pop is taken in the same cycle; refused pushes are lost.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10: begin
               level <= level + 1'b1;
               empty <= 1'b0;
               full  <= (level == LVL_FULL_M1);
            end
            2'b01: begin
               level <= level - 1'b1;
               full  <= 1'b0;
               empty <= (level == LVL_ONE);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/spi_mirror_fifo.sv
// Oversampled multi-lane SPI capture into a FIFO, replayed on a self-clocked SPI
// master port. Define SPI_MIRROR_FIFO_ERR_CNT_EN to add saturating error counters.
module spi_mirror_fifo
   import spi_mirror_fifo_pkg::*;
#(
   parameter int G_SPI_SIZE   = 4,
   parameter int G_WORD_WIDTH = 8,
   parameter int G_FIFO_DEPTH = 16,
   parameter int G_CLK_DIV    = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_spi_clk,
   input  logic                                 i_spi_cs_n,
   input  logic [G_SPI_SIZE-1:0]                i_spi_di,
   output logic                                 o_spi_clk,
   output logic                                 o_spi_cs_n,
   output logic [G_SPI_SIZE-1:0]                o_spi_do,
   input  logic                                 i_enable,
   input  logic                                 i_clr_err,
   output logic [$clog2(G_FIFO_DEPTH+1)-1:0]    o_fifo_level,
`ifdef SPI_MIRROR_FIFO_ERR_CNT_EN
   output logic [CNT_W-1:0]                     o_ovf_cnt,
   output logic [CNT_W-1:0]                     o_ferr_cnt,
`endif
   output logic                                 o_overflow,
   output logic                                 o_frame_err
);

   localparam int W  = G_WORD_WIDTH;
   localparam int DW = G_SPI_SIZE * G_WORD_WIDTH;
   localparam int BW = $clog2(G_WORD_WIDTH);
   localparam int HW = $clog2(2 * G_WORD_WIDTH);
   localparam int CW = $clog2(G_CLK_DIV);
   localparam logic [BW-1:0] BIT_LAST  = BW'(G_WORD_WIDTH - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(2 * G_WORD_WIDTH - 1);
   localparam logic [CW-1:0] DIV_LAST  = CW'(G_CLK_DIV - 1);

   logic                  sclk_meta, sclk_sync, sclk_prev;
   logic                  cs_meta, cs_sync, cs_prev;
   logic [G_SPI_SIZE-1:0] di_meta, di_sync;
   logic                  sclk_rise, cs_rise, cs_fall;
   logic [BW-1:0]         bit_cnt;
   logic [DW-1:0]         cap_sr, cap_next;
   logic                  cap_push, ferr_evt, ovf_evt;

   logic [DW-1:0]         fifo_rdata;
   logic                  fifo_full, fifo_empty, pop;

   replay_state_e         state;
   logic [CW-1:0]         div_cnt;
   logic [HW-1:0]         half_cnt;
   logic                  div_last;
   logic [DW-1:0]         out_sr, out_next;
   logic [G_SPI_SIZE-1:0] out_msb_next, load_msb;

   assign sclk_rise = sclk_sync & ~sclk_prev;
   assign cs_rise   = cs_sync & ~cs_prev;
   assign cs_fall   = ~cs_sync & cs_prev;

   always_comb begin
      cap_next     = '0;
      out_next     = '0;
      out_msb_next = '0;
      load_msb     = '0;
      for (int k = 0; k < G_SPI_SIZE; k++) begin
         cap_next[k*W +: W] = {cap_sr[k*W +: W-1], di_sync[k]};
         out_next[k*W +: W] = {out_sr[k*W +: W-1], 1'b0};
         out_msb_next[k]    = out_next[k*W + W-1];
         load_msb[k]        = fifo_rdata[k*W + W-1];
      end
   end

   // Capture: words complete mid-frame are pushed; a frame ending mid-word is an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_prev <= 1'b0;
         cs_meta   <= 1'b1;
         cs_sync   <= 1'b1;
         cs_prev   <= 1'b1;
         di_meta   <= '0;
         di_sync   <= '0;
         bit_cnt   <= '0;
         cap_sr    <= '0;
         cap_push  <= 1'b0;
         ferr_evt  <= 1'b0;
      end else begin
         sclk_meta <= i_spi_clk;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         cs_meta   <= i_spi_cs_n;
         cs_sync   <= cs_meta;
         cs_prev   <= cs_sync;
         di_meta   <= i_spi_di;
         di_sync   <= di_meta;
         cap_push  <= 1'b0;
         ferr_evt  <= 1'b0;
         if (cs_rise) begin
            ferr_evt <= (bit_cnt != '0);
            bit_cnt  <= '0;
         end else if (cs_fall) begin
            bit_cnt <= '0;
         end else if (sclk_rise && !cs_sync) begin
            cap_sr <= cap_next;
            if (bit_cnt == BIT_LAST) begin
               bit_cnt  <= '0;
               cap_push <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   assign ovf_evt = cap_push & fifo_full & ~pop;
   assign pop     = (state == ST_IDLE) & i_enable & ~fifo_empty;

   spi_mirror_fifo_mem #(
      .WIDTH (DW),
      .DEPTH (G_FIFO_DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cap_push),
      .wdata (cap_sr),
      .pop   (pop),
      .rdata (fifo_rdata),
      .level (o_fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign div_last = (div_cnt == DIV_LAST);

   // Replay: each half period is G_CLK_DIV cycles; SCLK rises after even halves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         div_cnt    <= '0;
         half_cnt   <= '0;
         out_sr     <= '0;
         o_spi_clk  <= RST_SCLK;
         o_spi_cs_n <= RST_CS_N;
         o_spi_do   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  out_sr     <= fifo_rdata;
                  o_spi_do   <= load_msb;
                  o_spi_cs_n <= 1'b0;
                  div_cnt    <= '0;
                  state      <= ST_LEAD;
               end
            end
            ST_LEAD: begin
               if (div_last) begin
                  div_cnt  <= '0;
                  half_cnt <= '0;
                  state    <= ST_SHIFT;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (div_last) begin
                  div_cnt  <= '0;
                  half_cnt <= half_cnt + 1'b1;
                  if (!half_cnt[0]) begin
                     o_spi_clk <= 1'b1;
                  end else begin
                     o_spi_clk <= 1'b0;
                     if (half_cnt == HALF_LAST) begin
                        state <= ST_TRAIL;
                     end else begin
                        out_sr   <= out_next;
                        o_spi_do <= out_msb_next;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_TRAIL: begin
               if (div_last) begin
                  div_cnt    <= '0;
                  o_spi_cs_n <= 1'b1;
                  o_spi_do   <= '0;
                  state      <= ST_GAP;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (div_last) begin
                  div_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_overflow  <= RST_FLAG;
         o_frame_err <= RST_FLAG;
      end else begin
         if (ovf_evt)        o_overflow <= 1'b1;
         else if (i_clr_err) o_overflow <= 1'b0;
         if (ferr_evt)        o_frame_err <= 1'b1;
         else if (i_clr_err)  o_frame_err <= 1'b0;
      end
   end

`ifdef SPI_MIRROR_FIFO_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_ovf_cnt  <= '0;
         o_ferr_cnt <= '0;
      end else begin
         o_ovf_cnt  <= cnt_next(o_ovf_cnt, ovf_evt, i_clr_err);
         o_ferr_cnt <= cnt_next(o_ferr_cnt, ferr_evt, i_clr_err);
      end
   end
`endif

endmodule

// File: tb/tb_spi_mirror_fifo.sv
// Directed bench for spi_mirror_fifo: table of single-frame replays plus
// hand-written overflow, frame-error, mid-frame reset and error-counter sequences.
module tb_spi_mirror_fifo;

   localparam int S     = 4;
   localparam int W     = 8;
   localparam int D     = 4;
   localparam int DEPTH = 4;
   localparam int HALF  = 5;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_spi_clk = 1'b0;
   logic          i_spi_cs_n = 1'b1;
   logic [S-1:0]  i_spi_di = '0;
   logic          o_spi_clk, o_spi_cs_n;
   logic [S-1:0]  o_spi_do;
   logic          i_enable = 1'b0;
   logic          i_clr_err = 1'b0;
   logic [LW-1:0] o_fifo_level;
   logic          o_overflow, o_frame_err;
`ifdef SPI_MIRROR_FIFO_ERR_CNT_EN
   logic [15:0]   o_ovf_cnt, o_ferr_cnt;
`endif

   spi_mirror_fifo #(
      .G_SPI_SIZE   (S),
      .G_WORD_WIDTH (W),
      .G_FIFO_DEPTH (DEPTH),
      .G_CLK_DIV    (D)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_spi_clk    (i_spi_clk),
      .i_spi_cs_n   (i_spi_cs_n),
      .i_spi_di     (i_spi_di),
      .o_spi_clk    (o_spi_clk),
      .o_spi_cs_n   (o_spi_cs_n),
      .o_spi_do     (o_spi_do),
      .i_enable     (i_enable),
      .i_clr_err    (i_clr_err),
      .o_fifo_level (o_fifo_level),
`ifdef SPI_MIRROR_FIFO_ERR_CNT_EN
      .o_ovf_cnt    (o_ovf_cnt),
      .o_ferr_cnt   (o_ferr_cnt),
`endif
      .o_overflow   (o_overflow),
      .o_frame_err  (o_frame_err)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;

   // output-port monitor and scoreboard queues
   logic [S*W-1:0] exp_q[$];
   logic [S*W-1:0] got_q[$];
   int             dur_q[$];
   int             rise_q[$];
   int             fall_q[$];
   logic           mon_active = 1'b0;
   logic           prev_cs = 1'b1;
   logic           prev_sclk = 1'b0;
   int             mon_start = 0;
   int             mon_rises = 0;
   logic [S*W-1:0] mon_word = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_active = 1'b0;
         prev_cs    = 1'b1;
         prev_sclk  = 1'b0;
      end else begin
         if (prev_cs && !o_spi_cs_n) begin
            mon_active = 1'b1;
            mon_start  = cyc;
            mon_rises  = 0;
            mon_word   = '0;
            fall_q.push_back(cyc);
         end
         if (mon_active && !prev_sclk && o_spi_clk) begin
            mon_rises++;
            for (int k = 0; k < S; k++)
               mon_word[k*W +: W] = {mon_word[k*W +: W-1], o_spi_do[k]};
         end
         if (mon_active && !prev_cs && o_spi_cs_n) begin
            mon_active = 1'b0;
            got_q.push_back(mon_word);
            dur_q.push_back(cyc - mon_start);
            rise_q.push_back(mon_rises);
         end
         prev_cs   = o_spi_cs_n;
         prev_sclk = o_spi_clk;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic spi_bits(input logic [S*W-1:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < S; k++) i_spi_di[k] = w[k*W + (W-1-i)];
         tick(HALF);
         i_spi_clk = 1'b1;
         tick(HALF);
         i_spi_clk = 1'b0;
      end
   endtask

   task automatic cs_begin();
      i_spi_cs_n = 1'b0;
      tick(HALF);
   endtask

   task automatic cs_end();
      tick(HALF);
      i_spi_cs_n = 1'b1;
      tick(HALF);
   endtask

   task automatic wait_frames(input string name, input int n, input int budget);
      int c;
      c = 0;
      while (got_q.size() < n && c < budget) begin
         tick(1);
         c++;
      end
      check(name, got_q.size(), n);
   endtask

   task automatic clear_mon();
      got_q.delete();
      dur_q.delete();
      rise_q.delete();
      fall_q.delete();
   endtask

   task automatic pulse_clr();
      i_clr_err = 1'b1;
      tick(1);
      i_clr_err = 1'b0;
   endtask

   typedef struct {
      logic [S*W-1:0] din;
      logic [S*W-1:0] exp_word;
      int             exp_low;
      int             exp_rises;
   } vec_t;

   vec_t vecs[3];
   logic [S*W-1:0] words[5];
   logic [S*W-1:0] e;
   int fc;

   initial begin
      // lane 0 occupies the low byte
      vecs[0] = '{din: 32'h00FF3CA5, exp_word: 32'h00FF3CA5, exp_low: 72, exp_rises: 8};
      vecs[1] = '{din: 32'h12345678, exp_word: 32'h12345678, exp_low: 72, exp_rises: 8};
      vecs[2] = '{din: 32'h80010FF0, exp_word: 32'h80010FF0, exp_low: 72, exp_rises: 8};
      words[0] = 32'h11111111;
      words[1] = 32'h22334455;
      words[2] = 32'hC3C3C3C3;
      words[3] = 32'h0F1E2D3C;
      words[4] = 32'hDEADBEEF;

      // reset state
      rst_n = 1'b0;
      tick(3);
      check("rst_level", 32'(o_fifo_level), 0);
      check("rst_cs_n", 32'(o_spi_cs_n), 1);
      check("rst_sclk", 32'(o_spi_clk), 0);
      check("rst_do", 32'(o_spi_do), 0);
      check("rst_ovf", 32'(o_overflow), 0);
      check("rst_ferr", 32'(o_frame_err), 0);
      rst_n = 1'b1;
      tick(3);

      // single-frame replays from the table
      i_enable = 1'b1;
      for (int v = 0; v < 3; v++) begin
         clear_mon();
         cs_begin();
         spi_bits(vecs[v].din, W);
         cs_end();
         wait_frames($sformatf("vec%0d_frame", v), 1, 300);
         if (got_q.size() > 0) begin
            check($sformatf("vec%0d_word", v), got_q[0], vecs[v].exp_word);
            check($sformatf("vec%0d_low", v), dur_q[0], vecs[v].exp_low);
            check($sformatf("vec%0d_rises", v), rise_q[0], vecs[v].exp_rises);
         end
         tick(D + 3);
         check($sformatf("vec%0d_level", v), 32'(o_fifo_level), 0);
      end

      // five words into a four-deep FIFO with replay disabled
      i_enable = 1'b0;
      clear_mon();
      cs_begin();
      for (int i = 0; i < 5; i++) spi_bits(words[i], W);
      cs_end();
      tick(10);
      check("ovf_level", 32'(o_fifo_level), 4);
      check("ovf_flag", 32'(o_overflow), 1);
      check("ovf_no_out", got_q.size(), 0);
      for (int i = 0; i < 4; i++) exp_q.push_back(words[i]);
      i_enable = 1'b1;
      wait_frames("ovf_frames", 4, 700);
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         e = exp_q.pop_front();
         check($sformatf("ovf_word%0d", i), got_q[i], e);
      end
      exp_q.delete();
      for (int i = 1; i < 4 && i < fall_q.size(); i++)
         check($sformatf("ovf_period%0d", i), fall_q[i] - fall_q[i-1], 77);
      tick(D + 3);
      check("ovf_drained", 32'(o_fifo_level), 0);
      pulse_clr();
      check("ovf_cleared", 32'(o_overflow), 0);

      // frame released after three bits, then a good frame
      clear_mon();
      cs_begin();
      spi_bits(32'hFFFFFFFF, 3);
      cs_end();
      tick(8);
      check("ferr_flag", 32'(o_frame_err), 1);
      check("ferr_level", 32'(o_fifo_level), 0);
      check("ferr_no_out", got_q.size(), 0);
      cs_begin();
      spi_bits(32'h81818181, W);
      cs_end();
      wait_frames("ferr_next_frame", 1, 300);
      if (got_q.size() > 0) check("ferr_next_word", got_q[0], 32'h81818181);
      tick(D + 3);
      pulse_clr();
      check("ferr_cleared", 32'(o_frame_err), 0);

      // reset in the middle of the shift phase
      clear_mon();
      cs_begin();
      spi_bits(32'hA5A5A5A5, W);
      cs_end();
      begin
         int c;
         c = 0;
         while (o_spi_clk !== 1'b1 && c < 200) begin
            tick(1);
            c++;
         end
         check("mid_sclk_seen", 32'(o_spi_clk), 1);
      end
      tick(2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_cs_n", 32'(o_spi_cs_n), 1);
      check("mid_rst_sclk", 32'(o_spi_clk), 0);
      check("mid_rst_do", 32'(o_spi_do), 0);
      check("mid_rst_level", 32'(o_fifo_level), 0);
      tick(2);
      rst_n = 1'b1;
      fc = fall_q.size();
      tick(300);
      check("mid_rst_no_frame", fall_q.size(), fc);
      check("mid_rst_cs_idle", 32'(o_spi_cs_n), 1);

`ifdef SPI_MIRROR_FIFO_ERR_CNT_EN
      // three frame errors and two dropped words
      check("cnt_rst_ovf", 32'(o_ovf_cnt), 0);
      check("cnt_rst_ferr", 32'(o_ferr_cnt), 0);
      i_enable = 1'b0;
      cs_begin();
      for (int i = 0; i < 6; i++) spi_bits(words[i % 5], W);
      cs_end();
      for (int i = 0; i < 3; i++) begin
         cs_begin();
         spi_bits(32'h5A5A5A5A, 2 + i);
         cs_end();
      end
      tick(10);
      check("cnt_ovf", 32'(o_ovf_cnt), 2);
      check("cnt_ferr", 32'(o_ferr_cnt), 3);
      pulse_clr();
      check("cnt_ovf_clr", 32'(o_ovf_cnt), 0);
      check("cnt_ferr_clr", 32'(o_ferr_cnt), 0);
      check("cnt_ovf_flag_clr", 32'(o_overflow), 0);
      check("cnt_ferr_flag_clr", 32'(o_frame_err), 0);
      clear_mon();
      i_enable = 1'b1;
      wait_frames("cnt_drain", 4, 700);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
